// File: rtl/lab3_pkg.sv
// Shared encodings for the Lab3 controller/datapath pair: function-select and
// datapath-select codes, consumed by the datapath, the controller and the bench.
package lab3_pkg;

  localparam logic [1:0] FS_HOLD = 2'b00;
  localparam logic [1:0] FS_INC  = 2'b01;
  localparam logic [1:0] FS_HALF = 2'b10;
  localparam logic [1:0] FS_TRIP = 2'b11;

  localparam logic SEL_LOAD = 1'b0;
  localparam logic SEL_RUN  = 1'b1;

endpackage

// File: rtl/collatz_alu.sv
// Combinational function unit: computes next R for the selected FS op and flags
// when the exact result would not fit in W bits.
module collatz_alu
  import lab3_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] r,
  input  logic [1:0]   fs,
  output logic [W-1:0] next_r,
  output logic         ovf
);

  localparam logic [W-1:0] W_ONE = {{(W-1){1'b0}}, 1'b1};

  // 3R needs up to two extra bits; anything above bit W-1 is an overflow.
  logic [W+1:0] w_trip;
  assign w_trip = {2'b00, r} + {1'b0, r, 1'b0};

  always_comb begin
    next_r = r;
    ovf    = 1'b0;
    case (fs)
      FS_HOLD: begin
        next_r = r;
        ovf    = 1'b0;
      end
      FS_INC: begin
        next_r = r + W_ONE;
        ovf    = (r == {W{1'b1}});
      end
      FS_HALF: begin
        next_r = r >> 1;
        ovf    = 1'b0;
      end
      default: begin
        next_r = w_trip[W-1:0];
        ovf    = |w_trip[W+1:W];
      end
    endcase
  end

endmodule

// File: rtl/collatz_datapath.sv
// Datapath half of the Lab3 Collatz pair: working register R, peak tracker,
// saturating step / odd-step counters and a sticky overflow flag.
module collatz_datapath
  import lab3_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic [W-1:0]  din,
  input  logic          SEL,
  input  logic          WEN,
  input  logic [1:0]    FS,
  output logic          One,
  output logic          X0,
  output logic [W-1:0]  value,
  output logic [W-1:0]  peak,
  output logic [CW-1:0] steps,
  output logic [CW-1:0] odd_steps,
  output logic          ovf
);

  localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] C_MAX = {CW{1'b1}};
  localparam logic [W-1:0]  W_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0]  r_value;
  logic [W-1:0]  r_peak;
  logic [CW-1:0] r_steps;
  logic [CW-1:0] r_odd_steps;
  logic          r_ovf;

  logic [W-1:0]  w_next;
  logic          w_alu_ovf;

  collatz_alu #(.W(W)) u_alu (
    .r      (r_value),
    .fs     (FS),
    .next_r (w_next),
    .ovf    (w_alu_ovf)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_value     <= '0;
      r_peak      <= '0;
      r_steps     <= '0;
      r_odd_steps <= '0;
      r_ovf       <= 1'b0;
    end else if (SEL == SEL_LOAD) begin
      // Load wins over any op selected this cycle, including its overflow.
      r_value     <= din;
      r_peak      <= din;
      r_steps     <= '0;
      r_odd_steps <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_value <= w_next;
      if (w_next > r_peak) begin
        r_peak <= w_next;
      end
      if ((FS != FS_HOLD) && (r_steps != C_MAX)) begin
        r_steps <= r_steps + C_ONE;
      end
      if (WEN && (r_odd_steps != C_MAX)) begin
        r_odd_steps <= r_odd_steps + C_ONE;
      end
      if (w_alu_ovf) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Status back to the controller comes only from registered R.
  assign One       = (r_value == W_ONE);
  assign X0        = r_value[0];
  assign value     = r_value;
  assign peak      = r_peak;
  assign steps     = r_steps;
  assign odd_steps = r_odd_steps;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_collatz_datapath.sv
// Directed bench for collatz_datapath: a W=8/CW=8 instance plus a CW=4 instance
// sharing the same stimulus so counter saturation is reachable in a few cycles.
module tb_collatz_datapath;
  import lab3_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       sel;
  logic       wen;
  logic [1:0] fs;

  logic       one, x0, ovf;
  logic [7:0] value, peak, steps, odd_steps;

  logic       one4, x04, ovf4;
  logic [7:0] value4, peak4;
  logic [3:0] steps4, odd_steps4;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];

  collatz_datapath #(.W(8), .CW(8)) dut (
    .CLK(clk), .reset(reset), .din(din), .SEL(sel), .WEN(wen), .FS(fs),
    .One(one), .X0(x0), .value(value), .peak(peak),
    .steps(steps), .odd_steps(odd_steps), .ovf(ovf)
  );

  collatz_datapath #(.W(8), .CW(4)) dut4 (
    .CLK(clk), .reset(reset), .din(din), .SEL(sel), .WEN(wen), .FS(fs),
    .One(one4), .X0(x04), .value(value4), .peak(peak4),
    .steps(steps4), .odd_steps(odd_steps4), .ovf(ovf4)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Apply inputs just after an edge, then sample 1ns after the next edge.
  task automatic cyc(input logic s, input logic [1:0] f, input logic w, input logic [7:0] d);
    sel = s;
    fs  = f;
    wen = w;
    din = d;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] fs_seq  [10];
  logic       wen_seq [10];

  initial begin
    reset = 1'b1;
    sel = SEL_RUN; fs = FS_TRIP; wen = 1'b1; din = 8'hff;
    @(posedge clk); #1;

    // Test 1: reset with active inputs
    cyc(SEL_RUN, FS_TRIP, 1'b1, 8'hff);
    check("rst_value", value, 0);
    check("rst_one", one, 0);
    check("rst_x0", x0, 0);
    check("rst_steps", steps, 0);
    check("rst_odd", odd_steps, 0);
    check("rst_peak", peak, 0);
    check("rst_ovf", ovf, 0);
    reset = 1'b0;

    // Test 2: load 6, HALF, TRIP, INC, HOLD
    cyc(SEL_LOAD, FS_HOLD, 1'b0, 8'd6);
    check("t2_load", value, 6);
    check("t2_load_peak", peak, 6);
    cyc(SEL_RUN, FS_HALF, 1'b0, 8'd0);
    check("t2_half", value, 3);
    check("t2_half_x0", x0, 1);
    check("t2_half_one", one, 0);
    cyc(SEL_RUN, FS_TRIP, 1'b1, 8'd0);
    check("t2_trip", value, 9);
    check("t2_trip_odd", odd_steps, 1);
    cyc(SEL_RUN, FS_INC, 1'b0, 8'd0);
    check("t2_inc", value, 10);
    check("t2_steps", steps, 3);
    check("t2_peak", peak, 10);
    cyc(SEL_RUN, FS_HOLD, 1'b0, 8'd0);
    check("t2_hold", value, 10);
    check("t2_hold_steps", steps, 3);

    // Test 3: controller-style stream from 6 down to 1
    fs_seq  = '{FS_HALF, FS_TRIP, FS_INC, FS_HALF, FS_TRIP, FS_INC,
                FS_HALF, FS_HALF, FS_HALF, FS_HALF};
    wen_seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_q = '{8'd3, 8'd9, 8'd10, 8'd5, 8'd15, 8'd16, 8'd8, 8'd4, 8'd2, 8'd1};
    cyc(SEL_LOAD, FS_HOLD, 1'b0, 8'd6);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] e;
      cyc(SEL_RUN, fs_seq[i], wen_seq[i], 8'd0);
      e = exp_q.pop_front();
      check($sformatf("t3_val%0d", i), value, e);
    end
    check("t3_one", one, 1);
    check("t3_peak", peak, 16);
    check("t3_steps", steps, 10);
    check("t3_odd", odd_steps, 2);
    check("t3_ovf", ovf, 0);

    // Test 4: overflow on TRIP and INC, sticky until load
    cyc(SEL_LOAD, FS_HOLD, 1'b0, 8'd100);
    cyc(SEL_RUN, FS_TRIP, 1'b0, 8'd0);
    check("t4_trip", value, 44);
    check("t4_trip_ovf", ovf, 1);
    check("t4_trip_peak", peak, 100);
    cyc(SEL_RUN, FS_HALF, 1'b0, 8'd0);
    check("t4_half", value, 22);
    check("t4_sticky", ovf, 1);
    cyc(SEL_LOAD, FS_HOLD, 1'b0, 8'd5);
    check("t4_reload", value, 5);
    check("t4_clr_ovf", ovf, 0);
    cyc(SEL_LOAD, FS_HOLD, 1'b0, 8'd255);
    cyc(SEL_RUN, FS_INC, 1'b0, 8'd0);
    check("t4_wrap", value, 0);
    check("t4_inc_ovf", ovf, 1);
    check("t4_wrap_peak", peak, 255);
    cyc(SEL_LOAD, FS_HOLD, 1'b0, 8'd85);
    cyc(SEL_RUN, FS_TRIP, 1'b0, 8'd0);
    check("t4_trip_edge", value, 255);
    check("t4_trip_edge_ovf", ovf, 0);

    // R=0 in run
    cyc(SEL_LOAD, FS_HOLD, 1'b0, 8'd0);
    cyc(SEL_RUN, FS_HALF, 1'b0, 8'd0);
    check("z_half", value, 0);
    cyc(SEL_RUN, FS_TRIP, 1'b0, 8'd0);
    check("z_trip", value, 0);
    check("z_one_lo", one, 0);
    cyc(SEL_RUN, FS_INC, 1'b0, 8'd0);
    check("z_inc", value, 1);
    check("z_one_hi", one, 1);

    // Test 5: counter saturation on the CW=4 instance
    cyc(SEL_LOAD, FS_HOLD, 1'b0, 8'd200);
    for (int i = 0; i < 15; i++) cyc(SEL_RUN, FS_HALF, 1'b1, 8'd0);
    check("t5_steps4_at15", steps4, 15);
    for (int i = 0; i < 5; i++) cyc(SEL_RUN, FS_HALF, 1'b1, 8'd0);
    check("t5_steps4", steps4, 15);
    check("t5_odd4", odd_steps4, 15);
    check("t5_steps8", steps, 20);
    check("t5_odd8", odd_steps, 20);
    check("t5_value4", value4, 0);

    // Test 6: load beats WEN/FS, then reset mid-run
    cyc(SEL_LOAD, FS_TRIP, 1'b1, 8'd7);
    check("t6_load", value, 7);
    check("t6_odd", odd_steps, 0);
    check("t6_steps", steps, 0);
    cyc(SEL_RUN, FS_TRIP, 1'b1, 8'd0);
    check("t6_trip", value, 21);
    check("t6_odd1", odd_steps, 1);
    reset = 1'b1;
    cyc(SEL_RUN, FS_TRIP, 1'b1, 8'd9);
    check("t6_rst_value", value, 0);
    check("t6_rst_peak", peak, 0);
    check("t6_rst_steps", steps, 0);
    check("t6_rst_odd", odd_steps, 0);
    check("t6_rst_ovf", ovf, 0);
    check("t6_rst_x0", x0, 0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
